// File: rtl/dcpu16_arb_pkg.sv
// ---------------------------------------------------------------------------
// dcpu16_arb_pkg
// Shared definitions for the DCPU16 two-port memory bus arbiter:
//   - grant FSM state encoding
//   - one-hot grant constants ({A,F})
//   - round-robin "last served" port encoding
//   - watchdog counter width and default error read data
// ---------------------------------------------------------------------------
package dcpu16_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GF   = 2'd1,
        ST_GA   = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_F    = 2'b01;
    localparam logic [1:0] GNT_A    = 2'b10;

    // Encoding of the round-robin pointer: which port was served last.
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_A = 1'b1;

    localparam int unsigned WDT_W        = 16;
    localparam logic [15:0] ERRD_DEFAULT = 16'hFFFF;

    function automatic logic [1:0] state_to_gnt(input arb_state_t s);
        logic [1:0] g;
        g = GNT_NONE;
        case (s)
            ST_GF:   g = GNT_F;
            ST_GA:   g = GNT_A;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/dcpu16_arb_wdt.sv
// ---------------------------------------------------------------------------
// dcpu16_arb_wdt
// Saturating watchdog counter for the memory bus arbiter.
//   clk  in  : clock
//   rst  in  : asynchronous active-low reset
//   clr  in  : clear the count (takes priority over inc)
//   inc  in  : a strobe cycle went unacknowledged
//   tmo  out : this unacknowledged cycle is the TMO-th in a row
// Parameter TMO: limit in cycles, 0 disables the watchdog.
// ---------------------------------------------------------------------------
module dcpu16_arb_wdt
    import dcpu16_arb_pkg::*;
#(
    parameter int unsigned TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tmo
);

    // The count holds the number of earlier unacknowledged cycles, so the
    // current cycle is the TMO-th one when the count equals TMO-1.
    localparam logic [WDT_W-1:0] LIMIT = WDT_W'((TMO == 0) ? 0 : (TMO - 1));
    localparam logic             WDT_EN = (TMO != 0);

    logic [WDT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tmo = WDT_EN && inc && (cnt_reg >= LIMIT);

endmodule

// File: rtl/dcpu16_mbus_arb.sv
// ---------------------------------------------------------------------------
// dcpu16_mbus_arb
// Shares one single-ported memory (M) between the DCPU16 fetch/save bus (F)
// and operand bus (A). Registered grant FSM, combinational M-bus mux and
// ack routing, plus a watchdog that terminates hung transactions with ERRD.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   fs_adr/stb/wre/dto, fs_dti/ack   F requester bus
//   ab_adr/stb/wre/dto, ab_dti/ack   A requester bus
//   mm_adr/stb/wre/dto, mm_dti/ack   shared memory bus
//   gnt                           one-hot grant {A,F}
//   err                           pulse on watchdog termination
// Parameters: TMO (watchdog limit, 0 = off), ERRD (read data on timeout).
// Build option: define DCPU16_ARB_RR_EN for round-robin arbitration;
// without it A has fixed priority on contention.
// ---------------------------------------------------------------------------
module dcpu16_mbus_arb
    import dcpu16_arb_pkg::*;
#(
    parameter int unsigned TMO  = 255,
    parameter logic [15:0] ERRD = ERRD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fs_adr,
    input  logic        fs_stb,
    input  logic        fs_wre,
    input  logic [15:0] fs_dto,
    output logic [15:0] fs_dti,
    output logic        fs_ack,
    input  logic [15:0] ab_adr,
    input  logic        ab_stb,
    input  logic        ab_wre,
    input  logic [15:0] ab_dto,
    output logic [15:0] ab_dti,
    output logic        ab_ack,
    output logic [15:0] mm_adr,
    output logic        mm_stb,
    output logic        mm_wre,
    output logic [15:0] mm_dto,
    input  logic [15:0] mm_dti,
    input  logic        mm_ack,
    output logic [1:0]  gnt,
    output logic        err
);

    arb_state_t  state_reg;
`ifdef DCPU16_ARB_RR_EN
    logic        lst_reg;
`endif

    logic        g_stb;
    logic        g_wre;
    logic [15:0] g_adr;
    logic [15:0] g_dto;
    logic        tmo_hit;
    logic        done;
    logic        abort;
    logic        wdt_clr;
    logic        wdt_inc;
    logic [15:0] dti_val;
    arb_state_t  contend_win;

    // Granted-port mux; everything is zero while idle.
    always_comb begin
        g_stb = 1'b0;
        g_wre = 1'b0;
        g_adr = '0;
        g_dto = '0;
        case (state_reg)
            ST_GF: begin
                g_stb = fs_stb;
                g_wre = fs_wre;
                g_adr = fs_adr;
                g_dto = fs_dto;
            end
            ST_GA: begin
                g_stb = ab_stb;
                g_wre = ab_wre;
                g_adr = ab_adr;
                g_dto = ab_dto;
            end
            default: ;
        endcase
    end

    // inc excludes mm_ack, so a real ack in the expiry cycle always wins.
    assign wdt_inc = g_stb && !mm_ack;
    assign done    = g_stb && (mm_ack || tmo_hit);
    assign abort   = (state_reg != ST_IDLE) && !g_stb;
    // Every grant change passes through idle, done or abort.
    assign wdt_clr = (state_reg == ST_IDLE) || done || abort;

    dcpu16_arb_wdt #(
        .TMO (TMO)
    ) u_wdt (
        .clk (clk),
        .rst (rst),
        .clr (wdt_clr),
        .inc (wdt_inc),
        .tmo (tmo_hit)
    );

    assign mm_stb = g_stb && !tmo_hit;
    assign mm_wre = g_wre;
    assign mm_adr = g_adr;
    assign mm_dto = g_dto;

    assign fs_ack = (state_reg == ST_GF) && done;
    assign ab_ack = (state_reg == ST_GA) && done;
    assign err    = tmo_hit;
    assign gnt    = state_to_gnt(state_reg);

    // Read data is broadcast; ack qualifies it. Held at zero during reset.
    assign dti_val = !rst ? 16'h0000 : (tmo_hit ? ERRD : mm_dti);
    assign fs_dti  = dti_val;
    assign ab_dti  = dti_val;

`ifdef DCPU16_ARB_RR_EN
    assign contend_win = (lst_reg == PORT_A) ? ST_GF : ST_GA;
`else
    assign contend_win = ST_GA;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
`ifdef DCPU16_ARB_RR_EN
            lst_reg   <= PORT_A;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fs_stb && ab_stb) begin
                        state_reg <= contend_win;
                    end else if (fs_stb) begin
                        state_reg <= ST_GF;
                    end else if (ab_stb) begin
                        state_reg <= ST_GA;
                    end
                end
                ST_GF: begin
                    if (!fs_stb) begin
                        state_reg <= ST_IDLE;
                    end else if (done) begin
`ifdef DCPU16_ARB_RR_EN
                        lst_reg <= PORT_F;
`endif
                        // fs_stb is high here, so otherwise the grant stays.
                        if (ab_stb) begin
                            state_reg <= ST_GA;
                        end
                    end
                end
                ST_GA: begin
                    if (!ab_stb) begin
                        state_reg <= ST_IDLE;
                    end else if (done) begin
`ifdef DCPU16_ARB_RR_EN
                        lst_reg <= PORT_A;
                        if (fs_stb) begin
                            state_reg <= ST_GF;
                        end
`endif
                        // Fixed priority: A keeps the bus while it requests.
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcpu16_mbus_arb.sv
`timescale 1ns/1ps
module tb_dcpu16_mbus_arb;

`ifdef DCPU16_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] fs_adr = '0, fs_dto = '0, ab_adr = '0, ab_dto = '0;
    logic        fs_stb = 1'b0, fs_wre = 1'b0, ab_stb = 1'b0, ab_wre = 1'b0;
    logic [15:0] mm_dti = 16'h5555;
    logic        mm_ack = 1'b0;
    logic [15:0] fs_dti, ab_dti, mm_adr, mm_dto;
    logic        fs_ack, ab_ack, mm_stb, mm_wre, err;
    logic [1:0]  gnt;

    int total = 0;
    int bad   = 0;

    dcpu16_mbus_arb #(
        .TMO  (4),
        .ERRD (16'hFFFF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .fs_adr (fs_adr),
        .fs_stb (fs_stb),
        .fs_wre (fs_wre),
        .fs_dto (fs_dto),
        .fs_dti (fs_dti),
        .fs_ack (fs_ack),
        .ab_adr (ab_adr),
        .ab_stb (ab_stb),
        .ab_wre (ab_wre),
        .ab_dto (ab_dto),
        .ab_dti (ab_dti),
        .ab_ack (ab_ack),
        .mm_adr (mm_adr),
        .mm_stb (mm_stb),
        .mm_wre (mm_wre),
        .mm_dto (mm_dto),
        .mm_dti (mm_dti),
        .mm_ack (mm_ack),
        .gnt    (gnt),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        fs_stb = 1'b0; ab_stb = 1'b0; fs_wre = 1'b0; ab_wre = 1'b0;
        mm_ack = 1'b0;
    endtask

    task automatic go_idle();
        @(negedge clk);
        clr_in();
        @(negedge clk);
        @(negedge clk);
        #1 chk("idle_gnt", gnt, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clr_in();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] e;

        // Reset state, with non-zero memory read data on the bus.
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_mm_stb", mm_stb, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_fs_ack", fs_ack, 1'b0);
        chk("rst_fs_dti", fs_dti, 16'h0000);
        chk("rst_ab_dti", ab_dti, 16'h0000);
        $display("txn reset state checked");
        @(negedge clk);
        rst = 1'b1;

        // 1: F read, zero-wait memory.
        @(negedge clk);
        fs_stb = 1'b1; fs_adr = 16'h0100; fs_wre = 1'b0;
        mm_ack = 1'b1; mm_dti = 16'h1234;
        #1;
        chk("t1_gnt_n", gnt, 2'b00);
        chk("t1_ack_n", fs_ack, 1'b0);
        @(negedge clk);
        #1;
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_mm_stb", mm_stb, 1'b1);
        chk("t1_mm_adr", mm_adr, 16'h0100);
        chk("t1_mm_wre", mm_wre, 1'b0);
        chk("t1_fs_ack", fs_ack, 1'b1);
        chk("t1_fs_dti", fs_dti, 16'h1234);
        chk("t1_ab_ack", ab_ack, 1'b0);
        chk("t1_err", err, 1'b0);
        $display("txn F read adr=0100 dti=%h", fs_dti);
        go_idle();

        // 2: contention right after reset, both held, immediate ack.
        do_reset();
        @(negedge clk);
        fs_stb = 1'b1; ab_stb = 1'b1; fs_adr = 16'h0200; ab_adr = 16'h0300;
        mm_ack = 1'b1;
        #1 chk("t2_gnt_n", gnt, 2'b00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            e = RR ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b10;
            chk("t2_gnt", gnt, e);
            chk("t2_fs_ack", fs_ack, e[0]);
            chk("t2_ab_ack", ab_ack, e[1]);
            chk("t2_mm_adr", mm_adr, e[0] ? 16'h0200 : 16'h0300);
            $display("txn contention cycle %0d gnt=%b", i, gnt);
        end
        go_idle();

        // 3: A write, memory acks in the third strobe cycle.
        @(negedge clk);
        ab_stb = 1'b1; ab_wre = 1'b1; ab_adr = 16'h8000; ab_dto = 16'hBEEF;
        fs_dto = 16'h1111; mm_ack = 1'b0;
        #1 chk("t3_gnt_n", gnt, 2'b00);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            mm_ack = (i == 3);
            #1;
            chk("t3_gnt", gnt, 2'b10);
            chk("t3_mm_stb", mm_stb, 1'b1);
            chk("t3_mm_wre", mm_wre, 1'b1);
            chk("t3_mm_dto", mm_dto, 16'hBEEF);
            chk("t3_mm_adr", mm_adr, 16'h8000);
            chk("t3_ab_ack", ab_ack, (i == 3));
            chk("t3_fs_ack", fs_ack, 1'b0);
        end
        $display("txn A write adr=8000 dto=BEEF");
        go_idle();

        // 4: watchdog expiry (TMO=4), then a real ack racing the expiry.
        @(negedge clk);
        fs_stb = 1'b1; fs_wre = 1'b0; fs_adr = 16'h0400;
        mm_ack = 1'b0; mm_dti = 16'h1234;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            chk("t4_mm_stb", mm_stb, (i != 4));
            chk("t4_fs_ack", fs_ack, (i == 4));
            chk("t4_err", err, (i == 4));
            chk("t4_fs_dti", fs_dti, (i == 4) ? 16'hFFFF : 16'h1234);
        end
        $display("txn F read timeout dti=FFFF");
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4) begin
                mm_ack = 1'b1;
                mm_dti = 16'hABCD;
            end
            #1;
            chk("t4b_mm_stb", mm_stb, 1'b1);
            chk("t4b_fs_ack", fs_ack, (i == 4));
            chk("t4b_err", err, 1'b0);
        end
        chk("t4b_fs_dti", fs_dti, 16'hABCD);
        $display("txn F read ack at expiry dti=%h", fs_dti);
        go_idle();

        // 5: asynchronous reset mid-transaction.
        @(negedge clk);
        fs_stb = 1'b1; mm_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_gnt_pre", gnt, 2'b01);
        chk("t5_stb_pre", mm_stb, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t5_mm_stb", mm_stb, 1'b0);
        chk("t5_gnt", gnt, 2'b00);
        chk("t5_fs_ack", fs_ack, 1'b0);
        chk("t5_err", err, 1'b0);
        @(negedge clk);
        clr_in();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fs_stb = 1'b1; ab_stb = 1'b1;
        #1 chk("t5_gnt_n", gnt, 2'b00);
        @(negedge clk);
        #1 chk("t5_first_win", gnt, RR ? 2'b01 : 2'b10);
        $display("txn async reset then contention gnt=%b", gnt);
        go_idle();

        // 6: granted F aborts; pending A granted after one idle cycle.
        @(negedge clk);
        fs_stb = 1'b1; ab_stb = 1'b0; mm_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_gnt_f", gnt, 2'b01);
        chk("t6_ack_f", fs_ack, 1'b0);
        @(negedge clk);
        fs_stb = 1'b0; ab_stb = 1'b1;
        #1;
        chk("t6_abort_ack", fs_ack, 1'b0);
        chk("t6_abort_stb", mm_stb, 1'b0);
        @(negedge clk);
        #1;
        chk("t6_idle", gnt, 2'b00);
        chk("t6_ab_ack", ab_ack, 1'b0);
        @(negedge clk);
        #1 chk("t6_gnt_a", gnt, 2'b10);
        $display("txn F abort then A grant gnt=%b", gnt);
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
